// File: rtl/tx_byte_sequencer.sv
// tx_byte_sequencer: feeds a parallel-to-serial shift register. It keeps one
// byte in a holding buffer and times load/shift strobes so that each bit
// stays on the line for CLKS_PER_BIT clocks. Bytes are chained with no idle
// gap, and an abort forces the line back to idle-high.
module tx_byte_sequencer #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                tx_valid,
  input  logic [NUM_BITS-1:0] tx_data,
  output logic                tx_ready,
  input  logic                tx_abort,
  output logic                load_enable,
  output logic                shift_enable,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic                byte_done,
  output logic                busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BITS);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BMAX = BW'(NUM_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [NUM_BITS-1:0]   hold_data_q;
  logic                  hold_full_q;

  // Raw strobes before reset gating; take marks a load from the buffer.
  logic le_raw, se_raw, bd_raw, take;
  logic accept;

  // Handshake is closed during reset, while full, and in an abort cycle.
  assign tx_ready = n_rst && !hold_full_q && !tx_abort;
  assign accept   = tx_valid && tx_ready;

  // State, bit timer and bit counter registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
    end
  end

  // Holding buffer: abort and loads empty it; accept fills it. A load needs
  // the buffer full while an accept needs it empty, so they never collide.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '1;
    end else if (tx_abort || take) begin
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_full_q <= 1'b1;
      hold_data_q <= tx_data;
    end
  end

  // Next-state and strobe decode; abort overrides every state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    le_raw  = 1'b0;
    se_raw  = 1'b0;
    bd_raw  = 1'b0;
    take    = 1'b0;
    if (tx_abort) begin
      // Loading all ones parks the serial line high.
      le_raw  = 1'b1;
      state_d = IDLE;
      timer_d = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) state_d = LOAD;
        end
        LOAD: begin
          le_raw  = 1'b1;
          take    = 1'b1;
          timer_d = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (timer_q == TMAX) begin
            timer_d = '0;
            if (bit_q == BMAX) begin
              bd_raw = 1'b1;
              bit_d  = '0;
              if (hold_full_q) begin
                // Chain the next byte on the last strobe: no idle gap.
                le_raw = 1'b1;
                take   = 1'b1;
              end else begin
                // Final shift pulls a 1 in behind the last bit.
                se_raw  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              se_raw = 1'b1;
              bit_d  = bit_q + 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held.
  assign load_enable  = n_rst && le_raw;
  assign shift_enable = n_rst && se_raw;
  assign byte_done    = n_rst && bd_raw;
  assign parallel_out = (n_rst && take) ? hold_data_q : '1;
  assign busy         = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_tx_byte_sequencer.sv
// Bench for tx_byte_sequencer with NUM_BITS=8, CLKS_PER_BIT=4. Each task
// drives one scenario and checks per-cycle output vectors; a background
// scoreboard matches every buffer load against the bytes handed over.
module tb_tx_byte_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_abort;
  logic       load_enable;
  logic       shift_enable;
  logic [7:0] parallel_out;
  logic       byte_done;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int overlap = 0;
  logic [7:0] exp_q[$];

  tx_byte_sequencer #(.NUM_BITS(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .n_rst(n_rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_abort(tx_abort), .load_enable(load_enable),
    .shift_enable(shift_enable), .parallel_out(parallel_out),
    .byte_done(byte_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: accepted bytes are queued, each non-abort load pops one.
  always @(posedge clk) begin
    logic [7:0] e;
    if (!n_rst || tx_abort) begin
      exp_q.delete();
    end else begin
      if (load_enable && shift_enable) overlap++;
      if (load_enable) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_load: got load of %h, expected no load", parallel_out);
        end else begin
          e = exp_q.pop_front();
          if (parallel_out !== e) begin
            n_err++;
            $display("FAIL sb_load: got %h, expected %h", parallel_out, e);
          end
        end
      end
      if (tx_valid && tx_ready) exp_q.push_back(tx_data);
    end
  end

  task automatic test_reset();
    logic [12:0] got, exp;
    for (int c = 0; c <= 3; c++) begin
      n_rst = (c >= 2); tx_valid = (c < 2); tx_data = 8'h11; tx_abort = 1'b0;
      #2;
      got = {load_enable, shift_enable, byte_done, busy, tx_ready, parallel_out};
      exp = {1'b0, 1'b0, 1'b0, 1'b0, c >= 2, 8'hFF};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset c=%0d got=%b expected=%b", c, got, exp);
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_single();
    logic [12:0] got, exp;
    for (int c = 0; c <= 40; c++) begin
      tx_valid = (c == 0); tx_data = 8'hA5;
      #2;
      got = {load_enable, shift_enable, byte_done, busy, tx_ready, parallel_out};
      exp = {c == 2, c >= 6 && c <= 34 && (c - 2) % 4 == 0, c == 34,
             c >= 1 && c <= 34, !(c == 1 || c == 2), (c == 2) ? 8'hA5 : 8'hFF};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL single c=%0d got=%b expected=%b", c, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got, exp;
    for (int c = 0; c <= 70; c++) begin
      tx_valid = (c <= 3); tx_data = (c == 0) ? 8'hA5 : 8'h3C;
      #2;
      got = {load_enable, shift_enable, byte_done, busy, tx_ready, parallel_out};
      exp = {c == 2 || c == 34,
             c >= 6 && c <= 66 && (c - 2) % 4 == 0 && c != 34,
             c == 34 || c == 66,
             c >= 1 && c <= 66,
             c == 0 || c == 3 || c >= 35,
             (c == 2) ? 8'hA5 : (c == 34) ? 8'h3C : 8'hFF};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL back_to_back c=%0d got=%b expected=%b", c, got, exp);
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_streaming();
    int nd = 0;
    int dones = 0;
    int loads[$];
    logic acc;
    overlap = 0;
    for (int c = 0; c < 140; c++) begin
      tx_valid = (nd < 4); tx_data = 8'(nd);
      #2;
      if (load_enable) loads.push_back(c);
      if (byte_done) dones++;
      acc = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (acc) nd++;
    end
    tx_valid = 1'b0;
    n_vec++;
    if (loads.size() != 4 || dones != 4 || nd != 4) begin
      n_err++;
      $display("FAIL stream_count: got loads=%0d dones=%0d accepts=%0d, expected 4 each",
               loads.size(), dones, nd);
    end
    for (int i = 1; i < loads.size(); i++) begin
      n_vec++;
      if (loads[i] - loads[i-1] != 32) begin
        n_err++;
        $display("FAIL stream_gap: got %0d cycles between loads, expected 32",
                 loads[i] - loads[i-1]);
      end
    end
    n_vec++;
    if (overlap != 0 || exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end: got overlap=%0d pending=%0d busy=%b, expected 0 0 0",
               overlap, exp_q.size(), busy);
    end
  endtask

  task automatic test_abort_mid();
    logic [12:0] got, exp;
    for (int c = 0; c <= 50; c++) begin
      tx_valid = (c <= 3); tx_data = (c == 0) ? 8'hA5 : 8'h3C;
      tx_abort = (c == 15);
      #2;
      got = {load_enable, shift_enable, byte_done, busy, tx_ready, parallel_out};
      exp = {c == 2 || c == 15, c == 6 || c == 10 || c == 14, 1'b0,
             c >= 1 && c <= 15, c == 0 || c == 3 || c >= 16,
             (c == 2) ? 8'hA5 : 8'hFF};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL abort_mid c=%0d got=%b expected=%b", c, got, exp);
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0; tx_abort = 1'b0;
  endtask

  task automatic test_abort_collide();
    logic [12:0] got, exp;
    for (int c = 0; c <= 12; c++) begin
      tx_valid = (c == 0); tx_abort = (c == 0); tx_data = 8'h55;
      #2;
      got = {load_enable, shift_enable, byte_done, busy, tx_ready, parallel_out};
      exp = {c == 0, 1'b0, 1'b0, 1'b0, c != 0, 8'hFF};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL abort_collide c=%0d got=%b expected=%b", c, got, exp);
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0; tx_abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [12:0] got, exp;
    for (int c = 0; c <= 45; c++) begin
      tx_valid = (c == 0); tx_data = 8'hA5;
      n_rst = !(c == 20 || c == 21);
      #2;
      got = {load_enable, shift_enable, byte_done, busy, tx_ready, parallel_out};
      exp = {c == 2, c >= 6 && c <= 18 && (c - 2) % 4 == 0, 1'b0,
             c >= 1 && c <= 20,
             c == 0 || (c >= 3 && c != 20 && c != 21),
             (c == 2) ? 8'hA5 : 8'hFF};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_mid c=%0d got=%b expected=%b", c, got, exp);
      end
      @(posedge clk); #1;
    end
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0; tx_valid = 1'b0; tx_abort = 1'b0; tx_data = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_streaming();
    test_abort_mid();
    test_abort_collide();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
